// File: rtl/cpu_dma_queue_pkt.sv
// cpu_dma_queue_pkt: packet queue between the user datapath and the CPU DMA engine.
//
// One store-and-forward FIFO per direction, each built on an inferred RAM.
//   RX: datapath (in_*) -> FIFO -> DMA read side (cpu_q_dma_rd*, first-word-fall-through).
//   TX: DMA write side (cpu_q_dma_wr*) -> FIFO -> datapath (out_*).
// Words become readable only once their packet's end-of-packet word has been written.
// An RX packet that overflows the FIFO is dropped as a whole rather than stalling the
// datapath. A TX watchdog rewinds a stranded partial packet without touching any
// packet that has already been committed.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr        datapath RX word, ctrl and write strobe
//   in_rdy                       registered RX space-available flag
//   out_data/out_ctrl/out_wr     datapath TX word, ctrl and write strobe
//   out_rdy                      downstream can accept a TX word
//   cpu_q_dma_pkt_avail          registered: at least one committed RX packet
//   cpu_q_dma_rd                 pop the RX head word
//   cpu_q_dma_rd_data/_ctrl      RX head word and ctrl
//   cpu_q_dma_nearly_full        registered: TX free space below TX_HEADROOM
//   cpu_q_dma_wr/_wr_data/_ctrl  TX write strobe, word and ctrl
//   tx_timeout                   one-cycle pulse when the watchdog discards a partial packet
//   rx_drop_count                saturating count of dropped RX packets
//   tx_timeout_count             saturating count of watchdog discards
module cpu_dma_queue_pkt #(
  parameter int unsigned DATA_WIDTH          = 64,
  parameter int unsigned CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int unsigned RX_DEPTH_BITS       = 9,
  parameter int unsigned TX_DEPTH_BITS       = 9,
  parameter int unsigned RX_HEADROOM         = 16,
  parameter int unsigned TX_HEADROOM         = 16,
  parameter int unsigned TX_WATCHDOG_TIMEOUT = 125000,
  parameter bit          BYTE_SWAP           = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  // datapath RX side
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  // datapath TX side
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  // DMA read side (RX FIFO)
  output logic                  cpu_q_dma_pkt_avail,
  input  logic                  cpu_q_dma_rd,
  output logic [DATA_WIDTH-1:0] cpu_q_dma_rd_data,
  output logic [CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
  // DMA write side (TX FIFO)
  output logic                  cpu_q_dma_nearly_full,
  input  logic                  cpu_q_dma_wr,
  input  logic [DATA_WIDTH-1:0] cpu_q_dma_wr_data,
  input  logic [CTRL_WIDTH-1:0] cpu_q_dma_wr_ctrl,
  // status
  output logic                  tx_timeout,
  output logic [15:0]           rx_drop_count,
  output logic [15:0]           tx_timeout_count
);

  localparam int unsigned RxDepth = 1 << RX_DEPTH_BITS;
  localparam int unsigned TxDepth = 1 << TX_DEPTH_BITS;
  localparam int unsigned RxPtrW  = RX_DEPTH_BITS + 1;
  localparam int unsigned TxPtrW  = TX_DEPTH_BITS + 1;
  localparam int unsigned WordW   = DATA_WIDTH + CTRL_WIDTH;

  localparam logic [RxPtrW-1:0] RxOne     = RxPtrW'(1);
  localparam logic [TxPtrW-1:0] TxOne     = TxPtrW'(1);
  localparam logic [RxPtrW-1:0] RxFullLvl = RxPtrW'(RxDepth);
  localparam logic [TxPtrW-1:0] TxFullLvl = TxPtrW'(TxDepth);
  localparam logic [31:0]       WdLoad    = 32'(TX_WATCHDOG_TIMEOUT);

  // Byte i <-> byte CTRL_WIDTH-1-i, ctrl bit i <-> bit CTRL_WIDTH-1-i. Self-inverse, so the
  // same functions serve both directions.
  function automatic logic [DATA_WIDTH-1:0] swap_data(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    if (BYTE_SWAP) begin
      for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
        r[8*i +: 8] = d[8*(int'(CTRL_WIDTH)-1-i) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [CTRL_WIDTH-1:0] swap_ctrl(input logic [CTRL_WIDTH-1:0] c);
    logic [CTRL_WIDTH-1:0] r;
    r = c;
    if (BYTE_SWAP) begin
      for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
        r[i] = c[int'(CTRL_WIDTH)-1-i];
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------------------
  // RX FIFO (datapath -> DMA). Stored in DMA-side byte order.
  // ---------------------------------------------------------------------------------------
  logic [WordW-1:0]  rx_mem [RxDepth];
  logic [RxPtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RxPtrW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RxPtrW-1:0] rx_commit_q, rx_commit_d;
  logic [RxPtrW-1:0] rx_cnt_q, rx_cnt_d;
  logic              rx_drop_q, rx_drop_d;
  logic              rx_wr_prev_zero_q, rx_wr_prev_zero_d;
  logic              rx_rd_prev_zero_q, rx_rd_prev_zero_d;
  logic [15:0]       rx_drop_cnt_q, rx_drop_cnt_d;
  logic              in_rdy_q, in_rdy_d;
  logic              pkt_avail_q;

  logic [RxPtrW-1:0]     rx_used, rx_free;
  logic                  rx_full, rx_in_eop, rx_we, rx_commit_ev, rx_drop_done;
  logic                  rx_rd_en, rx_rd_eop;
  logic [WordW-1:0]      rx_head;
  logic [CTRL_WIDTH-1:0] rx_head_ctrl;

  assign rx_used      = rx_wr_ptr_q - rx_rd_ptr_q;
  assign rx_free      = RxFullLvl - rx_used;
  assign rx_full      = (rx_used == RxFullLvl);
  // Datapath EOP: first nonzero-ctrl word after a zero-ctrl word (skips the module header).
  assign rx_in_eop    = in_wr && (in_ctrl != '0) && rx_wr_prev_zero_q;
  assign rx_head      = rx_mem[rx_rd_ptr_q[RX_DEPTH_BITS-1:0]];
  assign rx_head_ctrl = rx_head[DATA_WIDTH +: CTRL_WIDTH];
  assign rx_rd_en     = cpu_q_dma_rd && (rx_cnt_q != '0);
  assign rx_rd_eop    = rx_rd_en && (rx_head_ctrl != '0) && rx_rd_prev_zero_q;

  always_comb begin
    rx_wr_ptr_d   = rx_wr_ptr_q;
    rx_commit_d   = rx_commit_q;
    rx_drop_d     = rx_drop_q;
    rx_drop_cnt_d = rx_drop_cnt_q;
    rx_we         = 1'b0;
    rx_commit_ev  = 1'b0;
    rx_drop_done  = 1'b0;
    // The EOP tracker follows every presented word, including discarded ones, so that the
    // end of a dropped packet is still found.
    rx_wr_prev_zero_d = in_wr ? (in_ctrl == '0) : rx_wr_prev_zero_q;
    if (in_wr) begin
      if (rx_drop_q) begin
        if (rx_in_eop) begin
          rx_drop_d    = 1'b0;
          rx_drop_done = 1'b1;
        end
      end else if (rx_full) begin
        // Overflow: throw away the partial packet written so far.
        rx_wr_ptr_d = rx_commit_q;
        if (rx_in_eop) begin
          rx_drop_done = 1'b1;
        end else begin
          rx_drop_d = 1'b1;
        end
      end else begin
        rx_we       = 1'b1;
        rx_wr_ptr_d = rx_wr_ptr_q + RxOne;
        if (rx_in_eop) begin
          rx_commit_d  = rx_wr_ptr_q + RxOne;
          rx_commit_ev = 1'b1;
        end
      end
    end
    if (rx_drop_done && (rx_drop_cnt_q != 16'hFFFF)) begin
      rx_drop_cnt_d = rx_drop_cnt_q + 16'd1;
    end

    rx_rd_ptr_d       = rx_rd_en ? (rx_rd_ptr_q + RxOne) : rx_rd_ptr_q;
    rx_rd_prev_zero_d = rx_rd_en ? (rx_head_ctrl == '0) : rx_rd_prev_zero_q;

    rx_cnt_d = rx_cnt_q;
    if (rx_commit_ev && !rx_rd_eop) begin
      rx_cnt_d = rx_cnt_q + RxOne;
    end else if (!rx_commit_ev && rx_rd_eop) begin
      rx_cnt_d = rx_cnt_q - RxOne;
    end

    in_rdy_d = (32'(rx_free) >= RX_HEADROOM);
  end

  always_ff @(posedge clk) begin
    if (rx_we) begin
      rx_mem[rx_wr_ptr_q[RX_DEPTH_BITS-1:0]] <= {swap_ctrl(in_ctrl), swap_data(in_data)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_q       <= '0;
      rx_rd_ptr_q       <= '0;
      rx_commit_q       <= '0;
      rx_cnt_q          <= '0;
      rx_drop_q         <= 1'b0;
      rx_wr_prev_zero_q <= 1'b0;
      rx_rd_prev_zero_q <= 1'b0;
      rx_drop_cnt_q     <= '0;
      in_rdy_q          <= 1'b0;
      pkt_avail_q       <= 1'b0;
    end else begin
      rx_wr_ptr_q       <= rx_wr_ptr_d;
      rx_rd_ptr_q       <= rx_rd_ptr_d;
      rx_commit_q       <= rx_commit_d;
      rx_cnt_q          <= rx_cnt_d;
      rx_drop_q         <= rx_drop_d;
      rx_wr_prev_zero_q <= rx_wr_prev_zero_d;
      rx_rd_prev_zero_q <= rx_rd_prev_zero_d;
      rx_drop_cnt_q     <= rx_drop_cnt_d;
      in_rdy_q          <= in_rdy_d;
      pkt_avail_q       <= (rx_cnt_q != '0);
    end
  end

  assign in_rdy              = in_rdy_q;
  assign cpu_q_dma_pkt_avail = pkt_avail_q;
  assign cpu_q_dma_rd_data   = rx_head[DATA_WIDTH-1:0];
  assign cpu_q_dma_rd_ctrl   = rx_head_ctrl;
  assign rx_drop_count       = rx_drop_cnt_q;

  // ---------------------------------------------------------------------------------------
  // TX FIFO (DMA -> datapath). Stored in datapath-side byte order.
  // ---------------------------------------------------------------------------------------
  logic [WordW-1:0]      tx_mem [TxDepth];
  logic [TxPtrW-1:0]     tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TxPtrW-1:0]     tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TxPtrW-1:0]     tx_commit_q, tx_commit_d;
  logic [TxPtrW-1:0]     tx_cnt_q, tx_cnt_d;
  logic                  tx_mid_q, tx_mid_d;
  logic                  tx_rd_prev_zero_q, tx_rd_prev_zero_d;
  logic [31:0]           wd_timer_q, wd_timer_d;
  logic                  tx_timeout_q, tx_fire;
  logic [15:0]           tx_to_cnt_q, tx_to_cnt_d;
  logic                  nearly_full_q, nearly_full_d;
  logic                  out_wr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;

  logic [TxPtrW-1:0]     tx_used, tx_free;
  logic                  tx_full, tx_we, tx_wr_eop, tx_pending;
  logic                  tx_rd_en, tx_rd_eop;
  logic [WordW-1:0]      tx_head;
  logic [CTRL_WIDTH-1:0] tx_head_ctrl;

  assign tx_used      = tx_wr_ptr_q - tx_rd_ptr_q;
  assign tx_free      = TxFullLvl - tx_used;
  assign tx_full      = (tx_used == TxFullLvl);
  assign tx_we        = cpu_q_dma_wr && !tx_full;
  assign tx_wr_eop    = tx_we && (cpu_q_dma_wr_ctrl != '0);
  assign tx_pending   = (tx_wr_ptr_q != tx_commit_q);
  assign tx_head      = tx_mem[tx_rd_ptr_q[TX_DEPTH_BITS-1:0]];
  assign tx_head_ctrl = tx_head[DATA_WIDTH +: CTRL_WIDTH];
  // Never read past the commit point: partial packets stay invisible to the datapath.
  assign tx_rd_en     = out_rdy && (tx_rd_ptr_q != tx_commit_q) &&
                        ((tx_cnt_q != '0) || tx_mid_q);
  assign tx_rd_eop    = tx_rd_en && (tx_head_ctrl != '0) && tx_rd_prev_zero_q;

  always_comb begin
    wd_timer_d = wd_timer_q;
    tx_fire    = 1'b0;
    if (cpu_q_dma_wr || tx_rd_en) begin
      wd_timer_d = WdLoad;
    end else if (tx_pending) begin
      if (wd_timer_q == '0) begin
        tx_fire    = 1'b1;
        wd_timer_d = WdLoad;
      end else begin
        wd_timer_d = wd_timer_q - 32'd1;
      end
    end

    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_commit_d = tx_commit_q;
    if (tx_fire) begin
      tx_wr_ptr_d = tx_commit_q;
    end else if (tx_we) begin
      tx_wr_ptr_d = tx_wr_ptr_q + TxOne;
      if (tx_wr_eop) begin
        tx_commit_d = tx_wr_ptr_q + TxOne;
      end
    end

    tx_to_cnt_d = tx_to_cnt_q;
    if (tx_fire && (tx_to_cnt_q != 16'hFFFF)) begin
      tx_to_cnt_d = tx_to_cnt_q + 16'd1;
    end

    tx_rd_ptr_d       = tx_rd_en ? (tx_rd_ptr_q + TxOne) : tx_rd_ptr_q;
    tx_rd_prev_zero_d = tx_rd_en ? (tx_head_ctrl == '0) : tx_rd_prev_zero_q;
    tx_mid_d          = tx_rd_en ? !tx_rd_eop : tx_mid_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_wr_eop && !tx_rd_eop) begin
      tx_cnt_d = tx_cnt_q + TxOne;
    end else if (!tx_wr_eop && tx_rd_eop) begin
      tx_cnt_d = tx_cnt_q - TxOne;
    end

    nearly_full_d = (32'(tx_free) < TX_HEADROOM);
  end

  always_ff @(posedge clk) begin
    if (tx_we) begin
      tx_mem[tx_wr_ptr_q[TX_DEPTH_BITS-1:0]] <=
        {swap_ctrl(cpu_q_dma_wr_ctrl), swap_data(cpu_q_dma_wr_data)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_q       <= '0;
      tx_rd_ptr_q       <= '0;
      tx_commit_q       <= '0;
      tx_cnt_q          <= '0;
      tx_mid_q          <= 1'b0;
      tx_rd_prev_zero_q <= 1'b0;
      wd_timer_q        <= WdLoad;
      tx_timeout_q      <= 1'b0;
      tx_to_cnt_q       <= '0;
      nearly_full_q     <= 1'b0;
      out_wr_q          <= 1'b0;
      out_data_q        <= '0;
      out_ctrl_q        <= '0;
    end else begin
      tx_wr_ptr_q       <= tx_wr_ptr_d;
      tx_rd_ptr_q       <= tx_rd_ptr_d;
      tx_commit_q       <= tx_commit_d;
      tx_cnt_q          <= tx_cnt_d;
      tx_mid_q          <= tx_mid_d;
      tx_rd_prev_zero_q <= tx_rd_prev_zero_d;
      wd_timer_q        <= wd_timer_d;
      tx_timeout_q      <= tx_fire;
      tx_to_cnt_q       <= tx_to_cnt_d;
      nearly_full_q     <= nearly_full_d;
      out_wr_q          <= tx_rd_en;
      if (tx_rd_en) begin
        out_data_q <= tx_head[DATA_WIDTH-1:0];
        out_ctrl_q <= tx_head_ctrl;
      end
    end
  end

  assign out_wr                = out_wr_q;
  assign out_data              = out_data_q;
  assign out_ctrl              = out_ctrl_q;
  assign cpu_q_dma_nearly_full = nearly_full_q;
  assign tx_timeout            = tx_timeout_q;
  assign tx_timeout_count      = tx_to_cnt_q;

endmodule

// File: tb/tb_cpu_dma_queue_pkt.sv
// Bench for cpu_dma_queue_pkt: directed packets, expected words queued at stimulus time and
// checked by a negedge monitor whenever the DUT emits (out_wr) or the bench pops (RX).
module tb_cpu_dma_queue_pkt;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr, in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr, out_rdy;
  logic          cpu_q_dma_pkt_avail, cpu_q_dma_rd;
  logic [DW-1:0] cpu_q_dma_rd_data;
  logic [CW-1:0] cpu_q_dma_rd_ctrl;
  logic          cpu_q_dma_nearly_full, cpu_q_dma_wr;
  logic [DW-1:0] cpu_q_dma_wr_data;
  logic [CW-1:0] cpu_q_dma_wr_ctrl;
  logic          tx_timeout;
  logic [15:0]   rx_drop_count, tx_timeout_count;

  cpu_dma_queue_pkt #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .RX_DEPTH_BITS(4), .TX_DEPTH_BITS(5),
    .RX_HEADROOM(2), .TX_HEADROOM(4), .TX_WATCHDOG_TIMEOUT(100), .BYTE_SWAP(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cpu_q_dma_pkt_avail(cpu_q_dma_pkt_avail), .cpu_q_dma_rd(cpu_q_dma_rd),
    .cpu_q_dma_rd_data(cpu_q_dma_rd_data), .cpu_q_dma_rd_ctrl(cpu_q_dma_rd_ctrl),
    .cpu_q_dma_nearly_full(cpu_q_dma_nearly_full), .cpu_q_dma_wr(cpu_q_dma_wr),
    .cpu_q_dma_wr_data(cpu_q_dma_wr_data), .cpu_q_dma_wr_ctrl(cpu_q_dma_wr_ctrl),
    .tx_timeout(tx_timeout), .rx_drop_count(rx_drop_count),
    .tx_timeout_count(tx_timeout_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW+CW-1:0] rx_exp[$];
  logic [DW+CW-1:0] tx_exp[$];
  logic [DW+CW-1:0] mon_e;

  // Hand-swapped pair: datapath word 11_22_33_44_55_66_77_kk <-> DMA word kk_77_66_55_44_33_22_11.
  function automatic logic [63:0] dp_word(input logic [7:0] k);
    return {56'h11223344556677, k};
  endfunction
  function automatic logic [63:0] dma_word(input logic [7:0] k);
    return {k, 56'h77665544332211};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_wr) begin
      if (tx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected_word actual=%h/%h required=none", out_ctrl, out_data);
      end else begin
        mon_e = tx_exp.pop_front();
        check("tx_data", out_data, mon_e[DW-1:0]);
        check("tx_ctrl", {56'd0, out_ctrl}, {56'd0, mon_e[DW +: CW]});
      end
    end
    if (!reset && cpu_q_dma_rd) begin
      if (rx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected_pop actual=%h required=none", cpu_q_dma_rd_data);
      end else begin
        mon_e = rx_exp.pop_front();
        check("rx_data", cpu_q_dma_rd_data, mon_e[DW-1:0]);
        check("rx_ctrl", {56'd0, cpu_q_dma_rd_ctrl}, {56'd0, mon_e[DW +: CW]});
      end
    end
  end

  // RX packet: ctrl FF, 00..., 01 on the datapath; FF, 00..., 80 expected on the DMA side.
  task automatic rx_send(input int n, input int base, input bit stored);
    logic [7:0] c, ce;
    for (int i = 0; i < n; i++) begin
      c  = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h01 : 8'h00);
      ce = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h80 : 8'h00);
      in_wr   = 1'b1;
      in_ctrl = c;
      in_data = dp_word(8'(base + i));
      if (stored) rx_exp.push_back({ce, dma_word(8'(base + i))});
      tick();
    end
    in_wr = 1'b0;
  endtask

  task automatic rx_pop(input int n);
    cpu_q_dma_rd = 1'b1;
    repeat (n) tick();
    cpu_q_dma_rd = 1'b0;
  endtask

  // TX packet from DMA: ctrl 00..., 01 (or all 00 when partial); datapath sees 00..., 80.
  task automatic tx_send(input int n, input int base, input bit commit);
    for (int i = 0; i < n; i++) begin
      cpu_q_dma_wr      = 1'b1;
      cpu_q_dma_wr_ctrl = (commit && i == n - 1) ? 8'h01 : 8'h00;
      cpu_q_dma_wr_data = dma_word(8'(base + i));
      if (commit) tx_exp.push_back({((i == n - 1) ? 8'h80 : 8'h00), dp_word(8'(base + i))});
      tick();
    end
    cpu_q_dma_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first_k, pulses, run;
    reset = 1'b1;
    in_wr = 1'b0; in_ctrl = '0; in_data = '0;
    out_rdy = 1'b0; cpu_q_dma_rd = 1'b0;
    cpu_q_dma_wr = 1'b0; cpu_q_dma_wr_ctrl = '0; cpu_q_dma_wr_data = '0;
    tick(); tick();
    check("rst_out_wr", out_wr, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_pkt_avail", cpu_q_dma_pkt_avail, 0);
    check("rst_nearly_full", cpu_q_dma_nearly_full, 0);
    check("rst_tx_timeout", tx_timeout, 0);
    check("rst_rx_drop_count", rx_drop_count, 0);
    check("rst_tx_timeout_count", tx_timeout_count, 0);
    reset = 1'b0;
    tick(); tick();
    check("in_rdy_after_reset", in_rdy, 1);

    // TX first-word latency: EOP written in cycle N, out_wr in cycle N+2.
    out_rdy = 1'b1;
    tx_send(2, 8'hA0, 1'b1);
    check("tx_latency_n1", out_wr, 0);
    tick();
    check("tx_latency_n2", out_wr, 1);
    repeat (4) tick();
    check("tx_latency_drained", tx_exp.size(), 0);
    out_rdy = 1'b0;

    // Single RX packet, 8 words.
    rx_send(8, 8'h10, 1'b1);
    tick(); tick();
    check("rx1_pkt_avail", cpu_q_dma_pkt_avail, 1);
    rx_pop(8);
    tick(); tick();
    check("rx1_pkt_avail_fall", cpu_q_dma_pkt_avail, 0);
    check("rx1_drained", rx_exp.size(), 0);

    // RX overflow: 8-word packet committed, 12-word packet overflows 16-word FIFO and is dropped.
    rx_send(8, 8'h20, 1'b1);
    rx_send(12, 8'h30, 1'b0);
    rx_send(4, 8'h50, 1'b1);
    tick(); tick();
    check("rx_drop_count", rx_drop_count, 1);
    check("rx2_pkt_avail", cpu_q_dma_pkt_avail, 1);
    rx_pop(12);
    tick(); tick();
    check("rx2_pkt_avail_fall", cpu_q_dma_pkt_avail, 0);
    check("rx2_drained", rx_exp.size(), 0);

    // Pop of the only committed EOP in the same cycle as a new EOP write.
    rx_send(3, 8'h60, 1'b1);
    tick(); tick();
    check("rx3_pkt_avail", cpu_q_dma_pkt_avail, 1);
    for (int i = 0; i < 3; i++) begin
      cpu_q_dma_rd = 1'b1;
      in_wr   = 1'b1;
      in_ctrl = (i == 0) ? 8'hFF : ((i == 2) ? 8'h01 : 8'h00);
      in_data = dp_word(8'(8'h70 + i));
      rx_exp.push_back({((i == 0) ? 8'hFF : ((i == 2) ? 8'h80 : 8'h00)),
                        dma_word(8'(8'h70 + i))});
      tick();
    end
    cpu_q_dma_rd = 1'b0;
    in_wr = 1'b0;
    check("rx3_avail_same_cycle", cpu_q_dma_pkt_avail, 1);
    tick();
    check("rx3_avail_next", cpu_q_dma_pkt_avail, 1);
    tick();
    check("rx3_avail_hold", cpu_q_dma_pkt_avail, 1);
    rx_pop(3);
    tick(); tick();
    check("rx3_pkt_avail_fall", cpu_q_dma_pkt_avail, 0);
    check("rx3_drained", rx_exp.size(), 0);

    // TX watchdog: committed packet held, stranded 3-word partial discarded after 101 idle cycles.
    out_rdy = 1'b0;
    tx_send(4, 8'h80, 1'b1);
    tx_send(3, 8'h90, 1'b0);
    first_k = 0;
    pulses  = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (tx_timeout) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    check("wd_first_pulse_cycle", first_k, 101);
    check("wd_pulse_count", pulses, 1);
    check("wd_timeout_count", tx_timeout_count, 1);
    out_rdy = 1'b1;
    repeat (10) tick();
    check("wd_committed_drained", tx_exp.size(), 0);

    // TX streaming: three 5-word packets back to back.
    out_rdy = 1'b0;
    tx_send(5, 8'hB0, 1'b1);
    tx_send(5, 8'hC0, 1'b1);
    tx_send(5, 8'hD0, 1'b1);
    check("tx_stream_nearly_full", cpu_q_dma_nearly_full, 0);
    out_rdy = 1'b1;
    for (int k = 0; k < 20 && !out_wr; k++) tick();
    run = 0;
    while (out_wr && run < 40) begin
      run++;
      tick();
    end
    check("tx_stream_run", run, 15);
    check("tx_stream_drained", tx_exp.size(), 0);

    // Reset mid-TX-packet with data in both FIFOs.
    out_rdy = 1'b0;
    tx_send(3, 8'hE0, 1'b1);
    rx_send(4, 8'hF0, 1'b1);
    cpu_q_dma_wr      = 1'b1;
    cpu_q_dma_wr_ctrl = 8'h00;
    cpu_q_dma_wr_data = dma_word(8'hEE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_q_dma_wr = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    check("rst2_out_wr", out_wr, 0);
    check("rst2_out_data", out_data, 0);
    check("rst2_out_ctrl", out_ctrl, 0);
    check("rst2_in_rdy", in_rdy, 0);
    check("rst2_pkt_avail", cpu_q_dma_pkt_avail, 0);
    check("rst2_nearly_full", cpu_q_dma_nearly_full, 0);
    check("rst2_tx_timeout", tx_timeout, 0);
    check("rst2_rx_drop_count", rx_drop_count, 0);
    check("rst2_tx_timeout_count", tx_timeout_count, 0);
    out_rdy = 1'b1;
    repeat (10) tick();
    check("rst2_rx_empty", cpu_q_dma_pkt_avail, 0);
    check("rst2_in_rdy_back", in_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
